// File: rtl/demux_stream_1_to_n.sv
// demux_stream_1_to_n: routes a single input stream to N_OUT registered output lanes by select or round-robin.
// Latency: 1 cycle from an accepted input word to its lane showing o_valid.
// Backpressure: o_ready falls only when the target lane is full and its consumer stalls; other lanes keep flowing.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge) and asynchronous active-low reset
//   i_data/i_sel      input word and target lane (i_sel ignored in round-robin mode)
//   i_valid/o_ready   input handshake; o_ready never looks at i_valid
//   o_data/o_valid    per-lane word (lane k at [k*DATA_W +: DATA_W]) and valid, data is 0 while idle
//   i_ready           per-lane consumer ready
//   o_drop            one-cycle pulse after a word with an out-of-range select was swallowed
//   o_drop_cnt        saturating count of swallowed words
module demux_stream_1_to_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_W-1:0]       i_data,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [N_OUT*DATA_W-1:0] o_data,
    output logic [N_OUT-1:0]        o_valid,
    input  logic [N_OUT-1:0]        i_ready,
    output logic                    o_drop,
    output logic [CNT_W-1:0]        o_drop_cnt
);

    localparam bit RR_MODE = (MODE == 1);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  tgt;
    logic              sel_bad;
    logic [N_OUT-1:0]  tgt_oh;
    logic              lane_rdy;
    logic              accept;
    logic [N_OUT-1:0]  lane_load;
    logic [N_OUT-1:0]  lane_vld;
    logic [DATA_W-1:0] lane_dat [N_OUT];
    logic              drop_q;
    logic [CNT_W-1:0]  drop_cnt;

    // ------------------------------------------------------------------
    // Target lane selection
    // ------------------------------------------------------------------
    assign tgt = RR_MODE ? rr_ptr : i_sel;

    // The round-robin pointer never leaves 0..N_OUT-1, so only the
    // select-addressed mode can see an out-of-range target.
    assign sel_bad = !RR_MODE && (int'(tgt) >= N_OUT);

    // One-hot decode of the target. An out-of-range select decodes to all
    // zeros, which is what keeps a swallowed word away from every lane.
    always_comb begin
        tgt_oh = '0;
        for (int k = 0; k < N_OUT; k++) begin
            tgt_oh[k] = (int'(tgt) == k);
        end
    end

    // A lane can take a word if it is empty or is being drained this cycle.
    assign lane_rdy  = |(tgt_oh & (~lane_vld | i_ready));
    assign o_ready   = sel_bad | lane_rdy;
    assign accept    = i_valid & o_ready;
    assign lane_load = accept ? tgt_oh : '0;

    // ------------------------------------------------------------------
    // Lane output registers
    // ------------------------------------------------------------------
    // Load has priority over drain so a lane that is emptied and refilled
    // in the same cycle keeps o_valid high. Drained lanes clear their data
    // so an idle lane always reads as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_vld <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                lane_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (lane_load[k]) begin
                    lane_vld[k] <= 1'b1;
                    lane_dat[k] <= i_data;
                end else if (lane_vld[k] && i_ready[k]) begin
                    lane_vld[k] <= 1'b0;
                    lane_dat[k] <= '0;
                end
            end
        end
    end

    assign o_valid = lane_vld;

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane_out
        assign o_data[k*DATA_W +: DATA_W] = lane_dat[k];
    end

    // ------------------------------------------------------------------
    // Round-robin pointer
    // ------------------------------------------------------------------
    // Advances only on an accepted word, so a stalled lane holds the
    // pointer and strict lane order is preserved.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (RR_MODE && accept) begin
            if (int'(rr_ptr) == N_OUT - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop reporting
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_q <= accept & sel_bad;
            if (accept && sel_bad && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt;

endmodule
